// File: rtl/sdr_channel_arbiter.sv
// sdr_channel_arbiter: shares one SDRAM client port between NREQ requesters
// using round-robin grant, and inserts refresh cycles when refresh_req asks.
// A refresh that has waited REFRESH_MAX cycles pre-empts the next grant.
//
// Handshake (same on both sides): a requester raises req and holds its
// address stable. The responder answers with a one-cycle rdy pulse, and the
// data is valid only in that cycle. A req is never withdrawn by the arbiter
// once issued. Each mem_req or mem_refresh is closed by exactly one mem_rdy.
// A mem_rdy seen while IDLE is stray and is ignored.
module sdr_channel_arbiter #(
  parameter int NREQ        = 3,
  parameter int AW          = 25,
  parameter int DW          = 64,
  parameter int REFRESH_MAX = 64
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      cli_req,
  input  logic [NREQ*AW-1:0]   cli_addr,
  output logic [NREQ-1:0]      cli_rdy,
  output logic [DW-1:0]        cli_dout,
  output logic                 mem_req,
  output logic [AW-1:0]        mem_addr,
  input  logic                 mem_rdy,
  input  logic [DW-1:0]        mem_dout,
  output logic                 mem_refresh,
  input  logic                 refresh_req,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(REFRESH_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER    = 2'd1,
    S_REFRESH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              mem_ref_q, mem_ref_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   cli_rdy_q, cli_rdy_d;
  logic [DW-1:0]     cli_dout_q, cli_dout_d;
  logic [1:0]        gid_q, gid_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [WW-1:0]     wait_q, wait_d;

  logic              pick_valid;
  logic [1:0]        pick_id;
  logic              wait_full;
  int                idx;

  assign wait_full = (wait_q == WW'(REFRESH_MAX));

  // Round-robin search: first set request after the last served requester.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!pick_valid && cli_req[idx[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = 2'(idx);
      end
    end
  end

  // Next-state logic; refresh is considered before any client grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (refresh_req && (wait_full || !pick_valid)) state_d = S_REFRESH;
        else if (pick_valid)                           state_d = S_XFER;
      end
      S_XFER:    if (mem_rdy) state_d = S_IDLE;
      S_REFRESH: if (mem_rdy) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values, driven from the current state and transition.
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_ref_d  = mem_ref_q;
    busy_d     = busy_q;
    cli_rdy_d  = '0;
    cli_dout_d = cli_dout_q;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_REFRESH) begin
          mem_ref_d = 1'b1;
          busy_d    = 1'b1;
        end else if (state_d == S_XFER) begin
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          gid_d      = pick_id;
          mem_addr_d = cli_addr[int'(pick_id)*AW +: AW];
        end
      end
      S_XFER: begin
        if (mem_rdy) begin
          mem_req_d  = 1'b0;
          busy_d     = 1'b0;
          cli_rdy_d  = NREQ'(1) << gid_q;
          cli_dout_d = mem_dout;
          ptr_d      = gid_q;
        end
      end
      S_REFRESH: begin
        if (mem_rdy) begin
          mem_ref_d = 1'b0;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Refresh wait counter: counts pending-refresh cycles outside REFRESH, saturating.
  always_comb begin
    wait_d = wait_q;
    if (state_q == S_REFRESH && mem_rdy)                           wait_d = '0;
    else if (refresh_req && state_q != S_REFRESH && !wait_full)    wait_d = wait_q + WW'(1);
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Registered outputs, round-robin pointer and refresh wait counter.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_ref_q  <= 1'b0;
      busy_q     <= 1'b0;
      cli_rdy_q  <= '0;
      cli_dout_q <= '0;
      gid_q      <= '0;
      ptr_q      <= '0;
      wait_q     <= '0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_ref_q  <= mem_ref_d;
      busy_q     <= busy_d;
      cli_rdy_q  <= cli_rdy_d;
      cli_dout_q <= cli_dout_d;
      gid_q      <= gid_d;
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_refresh = mem_ref_q;
  assign busy        = busy_q;
  assign cli_rdy     = cli_rdy_q;
  assign cli_dout    = cli_dout_q;
  assign grant_id    = gid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sdr_channel_arbiter.sv
// Testbench for sdr_channel_arbiter: a cycle-by-cycle vector table for
// single-transfer, stray-rdy, refresh, dropped-request and reset cases, then
// hand-written sequences for round-robin order and refresh starvation.
module tb_sdr_channel_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 25;
  localparam int DW   = 64;
  localparam int RMAX = 64;

  localparam logic [AW-1:0] A0 = 25'h0100000;
  localparam logic [AW-1:0] A1 = 25'h0200040;
  localparam logic [AW-1:0] A2 = 25'h1ABCDE0;
  localparam logic [DW-1:0] D1 = 64'h1122334455667788;
  localparam logic [DW-1:0] D2 = 64'hA5A55A5A0F0FF0F0;
  localparam logic [DW-1:0] D3 = 64'h0123456789ABCDEF;
  localparam logic [DW-1:0] DX = 64'hDEADBEEF00000001;
  localparam logic [DW-1:0] DY = 64'hFFFFFFFFFFFFFFFF;

  // Clock/reset and DUT signals
  logic                 clk_sys = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      cli_req;
  logic [NREQ*AW-1:0]   cli_addr;
  logic [NREQ-1:0]      cli_rdy;
  logic [DW-1:0]        cli_dout;
  logic                 mem_req;
  logic [AW-1:0]        mem_addr;
  logic                 mem_rdy;
  logic [DW-1:0]        mem_dout;
  logic                 mem_refresh;
  logic                 refresh_req;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [1:0]           dbg_state;

  always #5 clk_sys = ~clk_sys;

  sdr_channel_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .REFRESH_MAX(RMAX)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cli_req     (cli_req),
    .cli_addr    (cli_addr),
    .cli_rdy     (cli_rdy),
    .cli_dout    (cli_dout),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdy     (mem_rdy),
    .mem_dout    (mem_dout),
    .mem_refresh (mem_refresh),
    .refresh_req (refresh_req),
    .grant_id    (grant_id),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Vector record: inputs for one edge, outputs expected just after it
  typedef struct {
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic            rdy;
    logic [DW-1:0]   dout;
    logic            rref;
    logic [1:0]      e_st;
    logic            e_mreq;
    logic [AW-1:0]   e_maddr;
    logic            e_mref;
    logic [NREQ-1:0] e_crdy;
    logic [DW-1:0]   e_cdout;
    logic [1:0]      e_gid;
    logic            e_busy;
  } vec_t;

  vec_t tbl[24];

  // Scoreboard counters
  int vectors     = 0;
  int miscompares = 0;

  // Responder state
  logic           auto_rdy = 1'b0;
  int             rdy_lat  = 2;
  int             age      = 0;
  int             cyc      = 0;
  logic [DW-1:0]  rdy_dout = '0;

  // Driver: advance one clock, sample just after the edge, run the auto responder
  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
    if ((mem_req & mem_refresh) === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL req_ref_excl: mem_req=%b mem_refresh=%b at cycle %0d, required not both", mem_req, mem_refresh, cyc);
    end
    if (auto_rdy) begin
      if (mem_req || mem_refresh) age++;
      else                        age = 0;
      mem_rdy = (age == rdy_lat);
      if (mem_rdy) begin
        mem_dout = {32'hC0DE5EED, 32'(cyc)};
        rdy_dout = mem_dout;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    auto_rdy    = 1'b0;
    mem_rdy     = 1'b0;
    age         = 0;
    cli_req     = '0;
    refresh_req = 1'b0;
    reset_n     = 1'b0;
    tick();
    tick();
    reset_n     = 1'b1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int id);
    case (id)
      0:       return A0;
      1:       return A1;
      default: return A2;
    endcase
  endfunction

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[6];
    int g, gap, grants, n;
    logic prev, done, ref_seen;

    reset_n     = 1'b0;
    cli_req     = '0;
    cli_addr    = {A2, A1, A0};
    mem_rdy     = 1'b0;
    mem_dout    = '0;
    refresh_req = 1'b0;

    //         rst  req     rdy  dout rref | st    mreq maddr mref crdy    cdout gid   busy
    tbl[0]  = '{1'b0, 3'b000, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 3'b000, '0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 3'b001, 1'b0, '0, 1'b0, 2'd1, 1'b1, A0, 1'b0, 3'b000, '0, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 3'b001, 1'b0, '0, 1'b0, 2'd1, 1'b1, A0, 1'b0, 3'b000, '0, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 3'b001, 1'b0, '0, 1'b0, 2'd1, 1'b1, A0, 1'b0, 3'b000, '0, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 3'b001, 1'b0, '0, 1'b0, 2'd1, 1'b1, A0, 1'b0, 3'b000, '0, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 3'b001, 1'b1, D1, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b001, D1, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 1'b0, '0, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b000, D1, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 3'b000, 1'b1, DX, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b000, D1, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 1'b0, '0, 1'b1, 2'd2, 1'b0, A0, 1'b1, 3'b000, D1, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 3'b000, 1'b0, '0, 1'b1, 2'd2, 1'b0, A0, 1'b1, 3'b000, D1, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 3'b000, 1'b1, '0, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b000, D1, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 3'b000, 1'b0, '0, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b000, D1, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 3'b100, 1'b0, '0, 1'b0, 2'd1, 1'b1, A2, 1'b0, 3'b000, D1, 2'd2, 1'b1};
    tbl[13] = '{1'b1, 3'b000, 1'b0, '0, 1'b0, 2'd1, 1'b1, A2, 1'b0, 3'b000, D1, 2'd2, 1'b1};
    tbl[14] = '{1'b1, 3'b000, 1'b1, D2, 1'b0, 2'd0, 1'b0, A2, 1'b0, 3'b100, D2, 2'd2, 1'b0};
    tbl[15] = '{1'b1, 3'b000, 1'b0, '0, 1'b0, 2'd0, 1'b0, A2, 1'b0, 3'b000, D2, 2'd2, 1'b0};
    tbl[16] = '{1'b1, 3'b010, 1'b0, '0, 1'b0, 2'd1, 1'b1, A1, 1'b0, 3'b000, D2, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 3'b010, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 3'b000, '0, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 3'b000, 1'b1, DY, 1'b0, 2'd0, 1'b0, '0, 1'b0, 3'b000, '0, 2'd0, 1'b0};
    tbl[19] = '{1'b1, 3'b000, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 3'b000, '0, 2'd0, 1'b0};
    tbl[20] = '{1'b1, 3'b001, 1'b0, '0, 1'b1, 2'd1, 1'b1, A0, 1'b0, 3'b000, '0, 2'd0, 1'b1};
    tbl[21] = '{1'b1, 3'b001, 1'b1, D3, 1'b1, 2'd0, 1'b0, A0, 1'b0, 3'b001, D3, 2'd0, 1'b0};
    tbl[22] = '{1'b1, 3'b000, 1'b0, '0, 1'b1, 2'd2, 1'b0, A0, 1'b1, 3'b000, D3, 2'd0, 1'b1};
    tbl[23] = '{1'b1, 3'b000, 1'b1, '0, 1'b0, 2'd0, 1'b0, A0, 1'b0, 3'b000, D3, 2'd0, 1'b0};

    // Table-driven vectors
    for (int i = 0; i < 24; i++) begin
      reset_n     = tbl[i].rst_n;
      cli_req     = tbl[i].req;
      mem_rdy     = tbl[i].rdy;
      mem_dout    = tbl[i].dout;
      refresh_req = tbl[i].rref;
      tick();
      vectors++;
      if (dbg_state !== tbl[i].e_st || mem_req !== tbl[i].e_mreq || mem_addr !== tbl[i].e_maddr ||
          mem_refresh !== tbl[i].e_mref || cli_rdy !== tbl[i].e_crdy || cli_dout !== tbl[i].e_cdout ||
          grant_id !== tbl[i].e_gid || busy !== tbl[i].e_busy) begin
        miscompares++;
        $display("FAIL row%0d: got st=%0d mreq=%b maddr=%h mref=%b crdy=%b cdout=%h gid=%0d busy=%b required st=%0d mreq=%b maddr=%h mref=%b crdy=%b cdout=%h gid=%0d busy=%b",
                 i, dbg_state, mem_req, mem_addr, mem_refresh, cli_rdy, cli_dout, grant_id, busy,
                 tbl[i].e_st, tbl[i].e_mreq, tbl[i].e_maddr, tbl[i].e_mref, tbl[i].e_crdy,
                 tbl[i].e_cdout, tbl[i].e_gid, tbl[i].e_busy);
      end
    end

    // Round-robin: all requests held, pointer 0 after reset
    rr_exp = '{1, 2, 0, 1, 2, 0};
    do_reset();
    rdy_lat  = 2;
    auto_rdy = 1'b1;
    cli_req  = '1;
    g = 0; gap = 0; prev = 1'b0;
    for (int c = 0; c < 200 && g < 6; c++) begin
      tick();
      if (cli_rdy != '0 && g > 0) begin
        chk("rr_cli_rdy", 64'(cli_rdy), 64'(3'b001 << rr_exp[g-1]));
        chk("rr_cli_dout", cli_dout, rdy_dout);
      end
      if (mem_req && !prev) begin
        chk("rr_grant_id", 64'(grant_id), 64'(rr_exp[g]));
        chk("rr_mem_addr", 64'(mem_addr), 64'(addr_of(rr_exp[g])));
        if (g > 0) chk("rr_idle_gap", 64'(gap), 64'd1);
        g++;
        gap = 0;
      end
      if (!mem_req) gap++;
      prev = mem_req;
    end
    chk("rr_grants_seen", 64'(g), 64'd6);
    cli_req = '0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (!busy && dbg_state == 2'd0) done = 1'b1;
    end
    chk("rr_drain", 64'(done), 64'd1);

    // Refresh starvation: refresh_req and all requests held continuously
    do_reset();
    rdy_lat     = 2;
    auto_rdy    = 1'b1;
    cli_req     = '1;
    refresh_req = 1'b1;
    n = 0; grants = 0; prev = 1'b0; ref_seen = 1'b0;
    for (int c = 0; c < 300 && !ref_seen; c++) begin
      tick();
      n++;
      if (mem_req && !prev) grants++;
      if (mem_refresh) begin
        ref_seen = 1'b1;
        chk("starve_ref_cycle", 64'(n), 64'd67);
        chk("starve_grants", 64'(grants), 64'd22);
        chk("starve_no_grant", 64'(mem_req), 64'd0);
      end
      prev = mem_req;
    end
    chk("starve_ref_seen", 64'(ref_seen), 64'd1);
    refresh_req = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (mem_req && !prev) begin
        done = 1'b1;
        chk("starve_next_gid", 64'(grant_id), 64'd2);
      end
      prev = mem_req;
    end
    chk("starve_resume", 64'(done), 64'd1);

    auto_rdy = 1'b0;
    mem_rdy  = 1'b0;
    cli_req  = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
